// File: rtl/input_panel_n_if.sv
// Front-panel bundle: raw push-buttons in, committed/edited selections and strobes out.
interface input_panel_n_if #(
  parameter int N_CH  = 6,
  parameter int N_DIG = 3
);
  logic                 Left, Right, Up, Down, Enter;
  logic [4*N_DIG-1:0]   Value, ValueCache;
  logic [N_CH-1:0]      Motor, MotorCache;
  logic [2:0]           Cursor;
  logic                 Commit, Reject;

  modport master (output Left, Right, Up, Down, Enter,
                  input  Value, ValueCache, Motor, MotorCache, Cursor, Commit, Reject);
  modport slave  (input  Left, Right, Up, Down, Enter,
                  output Value, ValueCache, Motor, MotorCache, Cursor, Commit, Reject);
endinterface

// File: rtl/input_panel_n.sv
// Front-panel entry: debounced buttons edit a one-hot motor cache and a BCD set-point
// cache; Enter commits both when the set-point is within range, otherwise rejects.
module input_panel_n #(
  parameter int N_CH       = 6,
  parameter int N_DIG      = 3,
  parameter int DB_CYCLES  = 4,
  parameter int REP_DELAY  = 0,
  parameter int REP_PERIOD = 8,
  parameter int VMAX       = 999
) (
  input  logic           sysclk,
  input  logic           rst,
  input_panel_n_if.slave pnl
);
  localparam int NB = 5;
  localparam int B_LEFT = 0, B_RIGHT = 1, B_UP = 2, B_DOWN = 3, B_ENTER = 4;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [NB-1:0] raw, s1_q, s2_q, db_q, dbp_q, ev;
  logic [CW-1:0] dbc_q [NB];
  logic [1:0]    rep;

  assign raw = {pnl.Enter, pnl.Down, pnl.Up, pnl.Right, pnl.Left};

  // Synchronise, then accept a new level only after DB_CYCLES consecutive samples of it.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      for (int b = 0; b < NB; b++) dbc_q[b] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      dbp_q <= db_q;
      for (int b = 0; b < NB; b++) begin
        if (s2_q[b] == db_q[b]) begin
          dbc_q[b] <= '0;
        end else if (dbc_q[b] == CW'(DB_CYCLES - 1)) begin
          db_q[b]  <= s2_q[b];
          dbc_q[b] <= '0;
        end else begin
          dbc_q[b] <= dbc_q[b] + CW'(1);
        end
      end
    end
  end

  generate
    if (REP_DELAY > 0) begin : g_rep
      localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      logic [1:0][RW-1:0] rc_q;
      logic [1:0]         ron_q;

      // Repeat tick: first at REP_DELAY cycles past the press, then every REP_PERIOD.
      always_comb begin
        rep = '0;
        for (int j = 0; j < 2; j++)
          rep[j] = db_q[B_UP+j] & (ron_q[j] ? (rc_q[j] == RW'(REP_PERIOD))
                                            : (rc_q[j] == RW'(REP_DELAY)));
      end

      // Hold counters per Up/Down; cleared while released so the press cycle sees 0.
      always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
          rc_q  <= '0;
          ron_q <= '0;
        end else begin
          for (int j = 0; j < 2; j++) begin
            if (!db_q[B_UP+j]) begin
              rc_q[j]  <= '0;
              ron_q[j] <= 1'b0;
            end else if (rep[j]) begin
              rc_q[j]  <= RW'(1);
              ron_q[j] <= 1'b1;
            end else begin
              rc_q[j]  <= rc_q[j] + RW'(1);
            end
          end
        end
      end
    end else begin : g_norep
      assign rep = '0;
    end
  endgenerate

  assign ev = (db_q & ~dbp_q) | {1'b0, rep[1], rep[0], 2'b00};

  logic [N_DIG-1:0][3:0] vc_q, vc_d, val_q, val_d;
  logic [N_CH-1:0]       mc_q, mc_d, mot_q, mot_d;
  logic [2:0]            cur_q, cur_d;
  logic                  com_q, com_d, rej_q, rej_d;
  logic [15:0]           dec;

  // Decimal value of the edit cache for the range check.
  always_comb begin
    dec = '0;
    for (int k = N_DIG - 1; k >= 0; k--)
      dec = 16'(dec * 16'd10) + {12'd0, vc_q[k]};
  end

  // Act on the single highest-priority event; everything else is dropped.
  always_comb begin
    vc_d  = vc_q;
    mc_d  = mc_q;
    cur_d = cur_q;
    val_d = val_q;
    mot_d = mot_q;
    com_d = 1'b0;
    rej_d = 1'b0;
    if (ev[B_ENTER]) begin
      if (dec <= 16'(VMAX)) begin
        val_d = vc_q;
        mot_d = mc_q;
        com_d = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end else if (ev[B_LEFT]) begin
      cur_d = (cur_q == 3'd0) ? 3'(N_DIG) : cur_q - 3'd1;
    end else if (ev[B_RIGHT]) begin
      cur_d = (cur_q == 3'(N_DIG)) ? 3'd0 : cur_q + 3'd1;
    end else if (ev[B_UP]) begin
      if (cur_q == 3'd0) mc_d = {mc_q[N_CH-2:0], mc_q[N_CH-1]};
      for (int k = 0; k < N_DIG; k++)
        if (cur_q == 3'(k + 1)) vc_d[k] = (vc_q[k] == 4'd9) ? 4'd0 : vc_q[k] + 4'd1;
    end else if (ev[B_DOWN]) begin
      if (cur_q == 3'd0) mc_d = {mc_q[0], mc_q[N_CH-1:1]};
      for (int k = 0; k < N_DIG; k++)
        if (cur_q == 3'(k + 1)) vc_d[k] = (vc_q[k] == 4'd0) ? 4'd9 : vc_q[k] - 4'd1;
    end
  end

  // Cache, cursor, committed outputs and strobes.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      vc_q  <= '0;
      mc_q  <= N_CH'(1);
      cur_q <= '0;
      val_q <= '0;
      mot_q <= '0;
      com_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      vc_q  <= vc_d;
      mc_q  <= mc_d;
      cur_q <= cur_d;
      val_q <= val_d;
      mot_q <= mot_d;
      com_q <= com_d;
      rej_q <= rej_d;
    end
  end

  assign pnl.Value      = val_q;
  assign pnl.Motor      = mot_q;
  assign pnl.ValueCache = vc_q;
  assign pnl.MotorCache = mc_q;
  assign pnl.Cursor     = cur_q;
  assign pnl.Commit     = com_q;
  assign pnl.Reject     = rej_q;
endmodule

// File: tb/tb_input_panel_n.sv
// Bench: two panels (default, and VMAX=500 with auto-repeat) share the button inputs;
// a behavioural model checks every cycle, plus directed tables and sequences.
module tb_input_panel_n;
  localparam int DB = 4;
  localparam logic [4:0] L = 5'b00001, R = 5'b00010, U = 5'b00100, D = 5'b01000, E = 5'b10000;

  logic sysclk = 1'b0;
  logic rst;
  logic [4:0] btn = '0;
  int n_cmp = 0, n_bad = 0;

  always #5 sysclk = ~sysclk;

  input_panel_n_if #(.N_CH(6), .N_DIG(3)) if0 ();
  input_panel_n_if #(.N_CH(6), .N_DIG(3)) if1 ();
  assign {if0.Enter, if0.Down, if0.Up, if0.Right, if0.Left} = btn;
  assign {if1.Enter, if1.Down, if1.Up, if1.Right, if1.Left} = btn;

  input_panel_n #(.N_CH(6), .N_DIG(3), .DB_CYCLES(DB), .REP_DELAY(0), .REP_PERIOD(8), .VMAX(999))
    dut0 (.sysclk(sysclk), .rst(rst), .pnl(if0));
  input_panel_n #(.N_CH(6), .N_DIG(3), .DB_CYCLES(DB), .REP_DELAY(20), .REP_PERIOD(8), .VMAX(500))
    dut1 (.sysclk(sysclk), .rst(rst), .pnl(if1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int rd [2] = '{0, 20};
  int rp [2] = '{8, 8};
  int vmx[2] = '{999, 500};
  logic [4:0] ms1[2], ms2[2], mdb[2];
  int mhist[2][5], mhold[2][5];
  int mdig[2][3];
  int mmot[2], mcur[2];
  logic [11:0] mval[2];
  logic [5:0] mmotc[2];
  logic mcom[2], mrej[2];

  function automatic logic [11:0] vc_of(input int i);
    logic [11:0] r;
    for (int k = 0; k < 3; k++) r[4*k +: 4] = 4'(mdig[i][k]);
    return r;
  endfunction

  task automatic mreset(input int i);
    ms1[i] = '0; ms2[i] = '0; mdb[i] = '0;
    for (int b = 0; b < 5; b++) begin mhist[i][b] = 0; mhold[i][b] = 0; end
    for (int k = 0; k < 3; k++) mdig[i][k] = 0;
    mmot[i] = 0; mcur[i] = 0; mval[i] = '0; mmotc[i] = '0; mcom[i] = 0; mrej[i] = 0;
  endtask

  task automatic mstep(input int i);
    bit ev[5];
    int pr[5] = '{4, 0, 1, 2, 3};
    int sel = -1;
    int dv, h, msk;
    for (int b = 0; b < 5; b++) begin
      h = mhold[i][b];
      ev[b] = mdb[i][b] && (h == 0 || ((b == 2 || b == 3) && rd[i] > 0 && h >= rd[i] &&
                                       (h - rd[i]) % rp[i] == 0));
    end
    for (int p = 0; p < 5; p++) if (sel < 0 && ev[pr[p]]) sel = pr[p];
    mcom[i] = 0; mrej[i] = 0;
    case (sel)
      4: begin
        dv = mdig[i][2] * 100 + mdig[i][1] * 10 + mdig[i][0];
        if (dv <= vmx[i]) begin mval[i] = vc_of(i); mmotc[i] = 6'd1 << mmot[i]; mcom[i] = 1; end
        else mrej[i] = 1;
      end
      0: mcur[i] = (mcur[i] == 0) ? 3 : mcur[i] - 1;
      1: mcur[i] = (mcur[i] == 3) ? 0 : mcur[i] + 1;
      2: if (mcur[i] == 0) mmot[i] = (mmot[i] + 1) % 6;
         else mdig[i][mcur[i]-1] = (mdig[i][mcur[i]-1] + 1) % 10;
      3: if (mcur[i] == 0) mmot[i] = (mmot[i] + 5) % 6;
         else mdig[i][mcur[i]-1] = (mdig[i][mcur[i]-1] + 9) % 10;
      default: ;
    endcase
    msk = (1 << DB) - 1;
    for (int b = 0; b < 5; b++) begin
      mhold[i][b] = mdb[i][b] ? mhold[i][b] + 1 : 0;
      mhist[i][b] = ((mhist[i][b] << 1) | int'(ms2[i][b])) & msk;
      if (!mdb[i][b] && mhist[i][b] == msk) mdb[i][b] = 1'b1;
      else if (mdb[i][b] && mhist[i][b] == 0) mdb[i][b] = 1'b0;
    end
    ms2[i] = ms1[i];
    ms1[i] = btn;
  endtask

  always @(posedge sysclk or negedge rst) begin
    for (int i = 0; i < 2; i++) if (!rst) mreset(i); else mstep(i);
  end

  task automatic cmp_model(input int i, input logic [11:0] vc, input logic [11:0] v,
                           input logic [5:0] mc, input logic [5:0] m, input logic [2:0] cu,
                           input logic co, input logic rj);
    string t;
    t = $sformatf("m%0d_", i);
    chk({t, "vcache"}, vc, vc_of(i));
    chk({t, "value"},  v,  mval[i]);
    chk({t, "mcache"}, mc, 6'd1 << mmot[i]);
    chk({t, "motor"},  m,  mmotc[i]);
    chk({t, "cursor"}, cu, 3'(mcur[i]));
    chk({t, "commit"}, co, mcom[i]);
    chk({t, "reject"}, rj, mrej[i]);
  endtask

  always @(negedge sysclk) begin
    cmp_model(0, if0.ValueCache, if0.Value, if0.MotorCache, if0.Motor, if0.Cursor, if0.Commit, if0.Reject);
    cmp_model(1, if1.ValueCache, if1.Value, if1.MotorCache, if1.Motor, if1.Cursor, if1.Commit, if1.Reject);
  end

  // ---------------- directed helpers ----------------
  int com0, rej0, com1, rej1;

  task automatic do_reset();
    @(negedge sysclk); #2 rst = 1'b0;
    repeat (2) @(negedge sysclk);
    #2 rst = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic press(input logic [4:0] b, input int hi);
    com0 = 0; rej0 = 0; com1 = 0; rej1 = 0;
    btn = b;
    for (int c = 0; c < 2 * hi; c++) begin
      @(negedge sysclk);
      com0 += int'(if0.Commit); rej0 += int'(if0.Reject);
      com1 += int'(if1.Commit); rej1 += int'(if1.Reject);
      if (c == hi - 1) btn = '0;
    end
  endtask

  typedef struct {
    logic [4:0]  b;
    logic [11:0] vc;
    logic [5:0]  mc;
    logic [2:0]  cur;
    logic [11:0] val;
    logic [5:0]  mot;
    int          ncom;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst = 1'b0;
    tbl[0]  = '{D, 12'h000, 6'b100000, 3'd0, 12'h000, 6'b000000, 0};
    tbl[1]  = '{D, 12'h000, 6'b010000, 3'd0, 12'h000, 6'b000000, 0};
    tbl[2]  = '{L, 12'h000, 6'b010000, 3'd3, 12'h000, 6'b000000, 0};
    tbl[3]  = '{D, 12'h900, 6'b010000, 3'd3, 12'h000, 6'b000000, 0};
    tbl[4]  = '{D, 12'h800, 6'b010000, 3'd3, 12'h000, 6'b000000, 0};
    tbl[5]  = '{L, 12'h800, 6'b010000, 3'd2, 12'h000, 6'b000000, 0};
    tbl[6]  = '{D, 12'h890, 6'b010000, 3'd2, 12'h000, 6'b000000, 0};
    tbl[7]  = '{D, 12'h880, 6'b010000, 3'd2, 12'h000, 6'b000000, 0};
    tbl[8]  = '{L, 12'h880, 6'b010000, 3'd1, 12'h000, 6'b000000, 0};
    tbl[9]  = '{D, 12'h889, 6'b010000, 3'd1, 12'h000, 6'b000000, 0};
    tbl[10] = '{D, 12'h888, 6'b010000, 3'd1, 12'h000, 6'b000000, 0};
    tbl[11] = '{E, 12'h888, 6'b010000, 3'd1, 12'h888, 6'b010000, 1};

    repeat (3) @(negedge sysclk);
    #2 rst = 1'b1;
    @(negedge sysclk);
    chk("rst_value", if0.Value, 12'h000);
    chk("rst_motor", if0.Motor, 6'b000000);
    chk("rst_mcache", if0.MotorCache, 6'b000001);
    chk("rst_cursor", if0.Cursor, 3'd0);

    // Motor rotation and digit editing, then commit
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].b, DB + 4);
      chk($sformatf("t%0d_vcache", i), if0.ValueCache, tbl[i].vc);
      chk($sformatf("t%0d_mcache", i), if0.MotorCache, tbl[i].mc);
      chk($sformatf("t%0d_cursor", i), if0.Cursor, tbl[i].cur);
      chk($sformatf("t%0d_value", i), if0.Value, tbl[i].val);
      chk($sformatf("t%0d_motor", i), if0.Motor, tbl[i].mot);
      chk($sformatf("t%0d_ncommit", i), com0, tbl[i].ncom);
    end

    // Range check on the VMAX=500 panel: 600 rejected, 500 accepted
    do_reset();
    press(L, DB + 4);
    repeat (6) press(U, DB + 4);
    press(E, DB + 4);
    chk("rj_nreject", rej1, 1);
    chk("rj_ncommit", com1, 0);
    chk("rj_value", if1.Value, 12'h000);
    chk("rj_motor", if1.Motor, 6'b000000);
    chk("rj_vcache", if1.ValueCache, 12'h600);
    chk("rj_cursor", if1.Cursor, 3'd3);
    press(D, DB + 4);
    press(E, DB + 4);
    chk("ok_ncommit", com1, 1);
    chk("ok_nreject", rej1, 0);
    chk("ok_value", if1.Value, 12'h500);
    chk("ok_motor", if1.Motor, 6'b000001);

    // Glitch shorter than debounce is ignored; Right wraps cursor 3 -> 0
    do_reset();
    press(L, DB + 4);
    btn = U;
    repeat (DB - 1) @(negedge sysclk);
    btn = '0;
    repeat (12) @(negedge sysclk);
    chk("gl_vcache", if0.ValueCache, 12'h000);
    chk("gl_cursor", if0.Cursor, 3'd3);
    press(R, DB + 4);
    chk("wrap_cursor", if0.Cursor, 3'd0);

    // Auto-repeat: press at hold 0, repeats at 20,28,36,44 within a 50-cycle hold
    do_reset();
    press(R, DB + 4);
    press(U, 50);
    chk("rep_vcache1", if1.ValueCache, 12'h005);
    chk("rep_vcache0", if0.ValueCache, 12'h001);

    // Simultaneous Enter+Down: only Enter acts
    do_reset();
    press(E | D, DB + 4);
    chk("sim_ncommit", com0, 1);
    chk("sim_mcache", if0.MotorCache, 6'b000001);
    chk("sim_motor", if0.Motor, 6'b000001);
    // Reset mid-hold of Down
    btn = D;
    repeat (12) @(negedge sysclk);
    chk("hold_mcache", if0.MotorCache, 6'b100000);
    #2 rst = 1'b0;
    #1;
    chk("ar_value", if0.Value, 12'h000);
    chk("ar_motor", if0.Motor, 6'b000000);
    chk("ar_vcache", if0.ValueCache, 12'h000);
    chk("ar_mcache", if0.MotorCache, 6'b000001);
    chk("ar_cursor", if0.Cursor, 3'd0);
    chk("ar_commit", if0.Commit, 1'b0);
    chk("ar_reject", if0.Reject, 1'b0);
    @(negedge sysclk);
    btn = '0;
    repeat (2) @(negedge sysclk);
    #2 rst = 1'b1;
    repeat (15) @(negedge sysclk);
    chk("post_mcache", if0.MotorCache, 6'b000001);

    // Randomised traffic against the model
    for (int s = 0; s < 400; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      btn = 5'(1 << $urandom_range(0, 4));
      else if (r < 8) btn = 5'($urandom_range(0, 31));
      else            btn = '0;
      repeat ($urandom_range(1, 14)) @(negedge sysclk);
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    btn = '0;
    repeat (20) @(negedge sysclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
